pwm_duty_ramper: RTL and testbench

PWM_DUTY_RAMPER -- requirements
Module: pwm_duty_ramper

---
 rtl/pwm_pkg.sv | 41 ++++
 rtl/pwm_tick_gen.sv | 38 +++
 rtl/pwm_duty_ramper.sv | 137 +++++++++++++
 tb/tb_pwm_duty_ramper.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared states, channel geometry and ramp arithmetic for the PWM duty ramper
package pwm_pkg;

  localparam int NUM_CH     = 4;
  localparam int DUTY_W     = 8;
  localparam int DUTY_BUS_W = NUM_CH * DUTY_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UPDATE = 2'd2
  } ramp_state_e;

  // Low bit of channel ch inside the flat duty bus.
  function automatic int lane_lo(input int ch);
    return ch * DUTY_W;
  endfunction

  // One ramp step toward tgt; a zero step still moves by one. The extra
  // bit keeps the sum/difference from wrapping past 0 or full scale.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt,
                                                  input logic [DUTY_W-1:0] stp);
    logic [DUTY_W:0]   step_eff;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   dif;
    logic [DUTY_W-1:0] res;
    step_eff = {1'b0, stp};
    if (stp == '0) step_eff = (DUTY_W+1)'(1);
    sum = {1'b0, cur} + step_eff;
    dif = {1'b0, cur} - step_eff;
    res = cur;
    if (cur < tgt) begin
      res = (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
    end else if (cur > tgt) begin
      res = (dif[DUTY_W] || (dif[DUTY_W-1:0] < tgt)) ? tgt : dif[DUTY_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - ramp tick divider, one tick every div+1 enabled cycles
module pwm_tick_gen #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [TICK_W-1:0] div,
  output logic              tick
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  // Wrap on >= so a divider lowered mid-count does not run the full range.
  assign tick = en && (cnt_q >= div);

  // Next count: clear wins, otherwise advance or wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q >= div) ? '0 : cnt_q + TICK_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramper.sv
// rtl/pwm_duty_ramper.sv - multi-channel PWM duty ramper; optional snap input under PWM_RAMP_SNAP_EN
module pwm_duty_ramper #(
  parameter int NUM_CH = pwm_pkg::NUM_CH,
  parameter int DUTY_W = pwm_pkg::DUTY_W,
  parameter int TICK_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tgt_wr,
  input  logic [$clog2(NUM_CH)-1:0] tgt_ch,
  input  logic [DUTY_W-1:0]         tgt_val,
  input  logic [DUTY_W-1:0]         step,
  input  logic [TICK_W-1:0]         tick_div,
  input  logic                      hold,
`ifdef PWM_RAMP_SNAP_EN
  input  logic                      snap,
`endif
  output logic [NUM_CH*DUTY_W-1:0]  duty,
  output logic [NUM_CH-1:0]         busy,
  output logic                      done
);

  import pwm_pkg::ramp_state_e;
  import pwm_pkg::ST_IDLE;
  import pwm_pkg::ST_WAIT;
  import pwm_pkg::ST_UPDATE;
  import pwm_pkg::lane_lo;
  import pwm_pkg::ramp_step;

  localparam int CH_W = $clog2(NUM_CH);

  ramp_state_e                    state_q, state_d;
  logic [CH_W-1:0]                idx_q, idx_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]  duty_q, duty_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]  target_q, target_d;
  logic                           done_q, done_d;
  logic                           cnt_en, cnt_clr, tick;
  logic                           busy_post;

  pwm_tick_gen #(.TICK_W(TICK_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .div  (tick_div),
    .tick (tick)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign duty[lane_lo(g) +: DUTY_W] = duty_q[g];
    assign busy[g]                    = (duty_q[g] != target_q[g]);
  end

  assign done = done_q;

  // Next state: target writes, tick wait, one-channel-per-cycle sweep, done on convergence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    duty_d    = duty_q;
    target_d  = target_q;
    done_d    = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    busy_post = 1'b0;

    if (tgt_wr) target_d[tgt_ch] = tgt_val;

    case (state_q)
      ST_IDLE: begin
        if (|busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = !hold;
        if (!(|busy)) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        // Ticks landing inside the sweep are dropped; the counter keeps wrapping.
        cnt_en         = 1'b1;
        duty_d[idx_q]  = ramp_step(duty_q[idx_q], target_q[idx_q], step);
        for (int i = 0; i < NUM_CH; i++) begin
          if (duty_d[i] != target_d[i]) busy_post = 1'b1;
        end
        if (idx_q == CH_W'(NUM_CH-1)) begin
          idx_d = '0;
          if (busy_post) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

`ifdef PWM_RAMP_SNAP_EN
    // Snap jumps every channel to its pre-edge target; a same-edge write is kept for later.
    if (snap) begin
      duty_d  = target_q;
      state_d = ST_IDLE;
      idx_d   = '0;
      done_d  = (state_q != ST_IDLE);
    end
`endif

    if (state_d == ST_IDLE) cnt_clr = 1'b1;
  end

  // State, duty, target and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramper.sv
// tb/tb_pwm_duty_ramper.sv - scoreboard bench for pwm_duty_ramper (snap test under PWM_RAMP_SNAP_EN)
module tb_pwm_duty_ramper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tgt_wr = 1'b0;
  logic [1:0]  tgt_ch = '0;
  logic [7:0]  tgt_val = '0;
  logic [7:0]  step = '0;
  logic [15:0] tick_div = '0;
  logic        hold = 1'b0;
`ifdef PWM_RAMP_SNAP_EN
  logic        snap = 1'b0;
`endif
  logic [31:0] duty;
  logic [3:0]  busy;
  logic        done;

  pwm_duty_ramper dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_wr   (tgt_wr),
    .tgt_ch   (tgt_ch),
    .tgt_val  (tgt_val),
    .step     (step),
    .tick_div (tick_div),
    .hold     (hold),
`ifdef PWM_RAMP_SNAP_EN
    .snap     (snap),
`endif
    .duty     (duty),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q [4][$];
  int   done_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   mdl_duty [4] = '{0, 0, 0, 0};
  int   wr_ch [4];
  int   wr_tv [4];

  task automatic chk(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pending();
    int p;
    p = done_q.size();
    for (int c = 0; c < 4; c++) p += exp_q[c].size();
    return p;
  endfunction

  task automatic flush();
    done_q.delete();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
  endtask

  // Reference rule: one ramp step toward the target, step 0 behaves as 1, clamped.
  function automatic int step_to(input int d, input int t, input int s);
    int se;
    se = (s == 0) ? 1 : s;
    if (d < t) return (d + se > t) ? t : d + se;
    if (d > t) return (d - se < t) ? t : d - se;
    return d;
  endfunction

  // Monitor: every lane change and every done pulse must match the next expected event.
  initial begin : monitor
    logic [31:0] prev;
    exp_t        e;
    int          cur;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = duty;
        continue;
      end
      for (int c = 0; c < 4; c++) begin
        cur = int'(duty[c*8 +: 8]);
        if (cur != int'(prev[c*8 +: 8])) begin
          chk($sformatf("duty%0d_change_expected", c), (exp_q[c].size() > 0) ? 1 : 0, 1);
          if (exp_q[c].size() > 0) begin
            e = exp_q[c].pop_front();
            chk($sformatf("duty%0d_value", c), cur, e.val);
            chk($sformatf("duty%0d_cycle", c), cyc, e.cyc);
          end
        end
      end
      if (done) begin
        done_seen++;
        chk("done_expected", (done_q.size() > 0) ? 1 : 0, 1);
        if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
      end
      prev = duty;
    end
  end

  // Writes wr_ch/wr_tv[0..n-1] on consecutive cycles starting at edge w and
  // queues the ramp that must follow. Optional hold window: hold is sampled
  // high on edges w+hold_at .. w+hold_at+hold_len-1, delaying later events.
  task automatic run_ramp(input int div, input int stp, input int n,
                          input int hold_at, input int hold_len);
    int w, nsw, len, v, t, c, budget, exp_busy;
    @(negedge clk);
    tick_div = 16'(div);
    step     = 8'(stp);
    hold     = 1'b0;
    @(negedge clk);
    w        = cyc + 1;
    nsw      = 0;
    exp_busy = 0;
    for (int i = 0; i < n; i++) begin
      v   = mdl_duty[wr_ch[i]];
      t   = wr_tv[i];
      len = 0;
      if (v != t) exp_busy |= (1 << wr_ch[i]);
      while (v != t) begin
        v = step_to(v, t, stp);
        c = w + div + 3 + wr_ch[i] + len * (div + 1);
        if (hold_at >= 0 && c >= w + hold_at) c += hold_len;
        exp_q[wr_ch[i]].push_back('{v, c});
        len++;
      end
      if (len > nsw) nsw = len;
      mdl_duty[wr_ch[i]] = t;
    end
    if (nsw > 0) begin
      c = w + div + 3 + (nsw - 1) * (div + 1) + 3;
      if (hold_at >= 0 && c >= w + hold_at) c += hold_len;
      done_q.push_back(c);
    end
    for (int i = 0; i < n; i++) begin
      tgt_wr  = 1'b1;
      tgt_ch  = 2'(wr_ch[i]);
      tgt_val = 8'(wr_tv[i]);
      @(negedge clk);
    end
    tgt_wr = 1'b0;
    chk("busy_after_write", int'(busy), exp_busy);
    budget = (nsw + 2) * (div + 1) + 60 + ((hold_at >= 0) ? hold_len : 0);
    for (int k = 0; k < budget; k++) begin
      if (hold_at >= 0)
        hold = (cyc >= w + hold_at - 1) && (cyc < w + hold_at - 1 + hold_len);
      if (pending() == 0) break;
      @(negedge clk);
    end
    hold = 1'b0;
    chk("pending_events", pending(), 0);
    flush();
    repeat (3) @(negedge clk);
    chk("busy_settled", int'(busy), 0);
    for (int ch = 0; ch < 4; ch++)
      chk($sformatf("duty%0d_final", ch), int'(duty[ch*8 +: 8]), mdl_duty[ch]);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: actual cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w, ds, perm[4], tmp, j, n, stp, div;
    repeat (3) @(negedge clk);
    chk("reset_duty", int'(duty), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_duty", int'(duty), 0);

    // Ramp up 0 -> 100 by 16 every 10 cycles.
    wr_ch[0] = 0; wr_tv[0] = 100;
    run_ramp(9, 16, 1, -1, 0);

    // Full-scale step down clamps at the target instead of wrapping.
    wr_ch[0] = 1; wr_tv[0] = 200;
    run_ramp(4, 255, 1, -1, 0);
    wr_ch[0] = 1; wr_tv[0] = 5;
    run_ramp(4, 255, 1, -1, 0);

    // Zero step moves one count per tick.
    wr_ch[0] = 2; wr_tv[0] = 3;
    run_ramp(4, 0, 1, -1, 0);

    // Writing a target equal to the idle duty must not pulse done.
    ds = done_seen;
    @(negedge clk);
    tgt_wr = 1'b1; tgt_ch = 2'd2; tgt_val = 8'(mdl_duty[2]);
    @(negedge clk);
    tgt_wr = 1'b0;
    chk("equal_write_busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    chk("equal_write_no_done", done_seen - ds, 0);

    // Hold for 50 cycles in WAIT after the first step of 100 -> 40.
    wr_ch[0] = 0; wr_tv[0] = 40;
    run_ramp(9, 16, 1, 18, 50);

    // Reset asserted while the sweep is servicing channel 2.
    ds = done_seen;
    @(negedge clk);
    tick_div = 16'd9; step = 8'd1;
    @(negedge clk);
    w = cyc + 1;
    exp_q[0].push_back('{step_to(mdl_duty[0], mdl_duty[0] ^ 8'h55, 1), w + 12});
    exp_q[1].push_back('{step_to(mdl_duty[1], mdl_duty[1] ^ 8'h55, 1), w + 13});
    for (int i = 0; i < 4; i++) begin
      tgt_wr = 1'b1; tgt_ch = 2'(i); tgt_val = 8'(mdl_duty[i] ^ 8'h55);
      @(negedge clk);
    end
    tgt_wr = 1'b0;
    while (cyc < w + 13) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midreset_duty", int'(duty), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_pending", pending(), 0);
    flush();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl_duty[i] = 0;
    repeat (20) @(negedge clk);
    chk("after_reset_duty", int'(duty), 0);
    chk("after_reset_busy", int'(busy), 0);
    chk("after_reset_no_done", done_seen - ds, 0);

    // Randomized multi-channel ramps.
    for (int it = 0; it < 12; it++) begin
      perm = '{0, 1, 2, 3};
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        wr_ch[i] = perm[i];
        wr_tv[i] = $urandom_range(0, 255);
      end
      if (wr_tv[0] == mdl_duty[wr_ch[0]]) wr_tv[0] = wr_tv[0] ^ 1;
      stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      div = $urandom_range(4, 12);
      run_ramp(div, stp, n, -1, 0);
    end

`ifdef PWM_RAMP_SNAP_EN
    // Snap during a ramp jumps straight to the target and pulses done.
    begin
      int t, v1;
      t  = (mdl_duty[0] < 128) ? 250 : 5;
      v1 = step_to(mdl_duty[0], t, 16);
      @(negedge clk);
      tick_div = 16'd9; step = 8'd16;
      @(negedge clk);
      w = cyc + 1;
      exp_q[0].push_back('{v1, w + 12});
      exp_q[0].push_back('{t, w + 13});
      done_q.push_back(w + 13);
      tgt_wr = 1'b1; tgt_ch = 2'd0; tgt_val = 8'(t);
      @(negedge clk);
      tgt_wr = 1'b0;
      while (cyc < w + 12) @(negedge clk);
      snap = 1'b1;
      @(negedge clk);
      snap = 1'b0;
      repeat (5) @(negedge clk);
      mdl_duty[0] = t;
      chk("snap_pending", pending(), 0);
      chk("snap_busy", int'(busy), 0);
      chk("snap_duty0", int'(duty[7:0]), t);
      flush();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
